// File: rtl/alu_pkg.sv
// Shared opcode map and FSM encoding for the alu family.
// Used by alu, alu_seq_unit and their benches.
package alu_pkg;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_XNOR = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SHL  = 4'd11;

    localparam logic [3:0] OP_RSVD_LO = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_reserved(input logic [3:0] op);
        return op >= OP_RSVD_LO;
    endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/response valid-ready channels of alu_seq_unit.
// master = op issuer, slave = the ALU unit.
interface alu_seq_unit_if #(
    parameter int WIDTH = 4
);

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_x;
    logic [WIDTH-1:0] req_y;
    logic [3:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_out;
    logic             rsp_cout;
    logic             rsp_err;

    modport master (
        output req_valid, req_x, req_y, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_cout, rsp_err
    );

    modport slave (
        input  req_valid, req_x, req_y, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_cout, rsp_err
    );

endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier, one partial product per cycle.
// done is high during the last step; product is the final value then.
module alu_seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_nxt;

    assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Expose the step result so the last step and RESP share one edge.
    assign done    = (cnt_q == CW'(1));
    assign product = acc_nxt;

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked sequential ALU with iterative multiply.
// Define ALU_SEQ_FAST_MUL_EN for a single-cycle combinational multiply.
module alu_seq_unit #(
    parameter int WIDTH = 4,
    parameter int SHAMT = 2
) (
    input  logic clk,
    input  logic rst,
    alu_seq_unit_if.slave bus
);

    import alu_pkg::*;

    state_e state_q, state_d;

    logic [WIDTH-1:0]   out_q, out_d;
    logic               cout_q, cout_d;
    logic               err_q, err_d;

    logic               accept;
    logic               go_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   x, y;
    logic [WIDTH-1:0]   ev_out;
    logic               ev_cout;
    logic               ev_err;

    assign x      = bus.req_x;
    assign y      = bus.req_y;
    assign accept = (state_q == ST_IDLE) && bus.req_valid;

`ifdef ALU_SEQ_FAST_MUL_EN
    assign prod     = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    assign mul_done = 1'b0;
    assign go_mul   = 1'b0;
`else
    assign go_mul = (bus.req_op == OP_MUL);

    alu_seq_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && go_mul),
        .a      (x),
        .b      (y),
        .done   (mul_done),
        .product(prod)
    );
`endif

    assign sum  = {1'b0, x} + {1'b0, y};
    assign diff = {1'b0, x} - {1'b0, y};

    always_comb begin
        ev_out  = '0;
        ev_cout = 1'b0;
        ev_err  = 1'b0;
        if (is_reserved(bus.req_op)) begin
            ev_err = 1'b1;
        end else begin
            unique case (bus.req_op)
                OP_PASS: ev_out = x;
                OP_ADD: begin
                    ev_out  = sum[WIDTH-1:0];
                    ev_cout = sum[WIDTH];
                end
                OP_SUB: begin
                    ev_out  = diff[WIDTH-1:0];
                    ev_cout = (x < y);
                end
                OP_MUL: begin
                    ev_out  = prod[WIDTH-1:0];
                    ev_cout = |prod[2*WIDTH-1:WIDTH];
                end
                OP_AND:  ev_out = x & y;
                OP_NAND: ev_out = ~(x & y);
                OP_OR:   ev_out = x | y;
                OP_NOR:  ev_out = ~(x | y);
                OP_XOR:  ev_out = x ^ y;
                OP_XNOR: ev_out = ~(x ^ y);
                OP_SHR: begin
                    ev_out  = x >> SHAMT;
                    ev_cout = |x[SHAMT-1:0];
                end
                OP_SHL: begin
                    ev_out  = x << SHAMT;
                    ev_cout = |x[WIDTH-1:WIDTH-SHAMT];
                end
                default: ev_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = go_mul ? ST_MUL : ST_RESP;
            end
            ST_MUL: begin
                if (mul_done) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result registers only change on accept or multiply completion.
    always_comb begin
        out_d  = out_q;
        cout_d = cout_q;
        err_d  = err_q;
        if (accept && !go_mul) begin
            out_d  = ev_out;
            cout_d = ev_cout;
            err_d  = ev_err;
        end else if ((state_q == ST_MUL) && mul_done) begin
            out_d  = prod[WIDTH-1:0];
            cout_d = |prod[2*WIDTH-1:WIDTH];
            err_d  = 1'b0;
        end
    end

    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_RESP);
        bus.rsp_out   = out_q;
        bus.rsp_cout  = cout_q;
        bus.rsp_err   = err_q;
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit (either ALU_SEQ_FAST_MUL_EN build).
// Drives and samples 1 time unit after each rising edge.
module tb_alu_seq_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

`ifdef ALU_SEQ_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 5;
`endif

  alu_seq_unit_if #(.WIDTH(4)) bus ();

  alu_seq_unit #(
    .WIDTH(4),
    .SHAMT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string t,
    input logic  ok
  );
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s", t);
    end
  endtask

  task automatic do_op(
    input string      tag,
    input logic [3:0] x,
    input logic [3:0] y,
    input logic [3:0] op,
    input logic [3:0] eo,
    input logic       ec,
    input logic       ee,
    input int         lat
  );
    int n;
    bus.req_valid = 1'b1;
    bus.req_x     = x;
    bus.req_y     = y;
    bus.req_op    = op;
    chk({tag, "_rdy"}, bus.req_ready === 1'b1);
    tick();
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n === lat);
    chk({tag, "_out"}, bus.rsp_out === eo);
    chk({tag, "_cout"}, bus.rsp_cout === ec);
    chk({tag, "_err"}, bus.rsp_err === ee);
    tick();
  endtask

  logic [3:0] b2b_op [4] = '{4'd1, 4'd2, 4'd6, 4'd7};
  logic [3:0] b2b_out[4] = '{4'd9, 4'd3, 4'd7, 4'd8};

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_req_ready", bus.req_ready === 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid === 1'b0);
    chk("rst_out", bus.rsp_out === 4'd0);
    chk("rst_cout", bus.rsp_cout === 1'b0);
    chk("rst_err", bus.rsp_err === 1'b0);

    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_x     = 4'd6;
    bus.req_y     = 4'd3;
    for (int i = 0; i < 4; i++) begin
      bus.req_op = b2b_op[i];
      chk("b2b_rdy", bus.req_ready === 1'b1);
      tick();
      chk("b2b_gap", bus.req_ready === 1'b0);
      chk("b2b_valid", bus.rsp_valid === 1'b1);
      chk("b2b_out", bus.rsp_out === b2b_out[i]);
      chk("b2b_cout", bus.rsp_cout === 1'b0);
      tick();
    end
    bus.req_valid = 1'b0;

    do_op("mul", 4'd6, 4'd3, 4'd3, 4'd2, 1'b1, 1'b0, MUL_LAT);
    do_op("shl", 4'd6, 4'd0, 4'd11, 4'd8, 1'b1, 1'b0, 1);
    do_op("shr", 4'd5, 4'd0, 4'd10, 4'd1, 1'b1, 1'b0, 1);
    do_op("sub", 4'd2, 4'd3, 4'd2, 4'd15, 1'b1, 1'b0, 1);
    do_op("and", 4'd12, 4'd10, 4'd4, 4'd8, 1'b0, 1'b0, 1);
    do_op("xnor", 4'd12, 4'd10, 4'd9, 4'd9, 1'b0, 1'b0, 1);
    do_op("mul0", 4'd3, 4'd5, 4'd3, 4'd15, 1'b0, 1'b0, MUL_LAT);

    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_x     = 4'd9;
    bus.req_y     = 4'd9;
    bus.req_op    = 4'd1;
    tick();
    bus.req_x  = 4'd4;
    bus.req_op = 4'd0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", bus.rsp_valid === 1'b1);
      chk("bp_out", bus.rsp_out === 4'd2);
      chk("bp_cout", bus.rsp_cout === 1'b1);
      chk("bp_noacc", bus.req_ready === 1'b0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    chk("bp_hs_valid", bus.rsp_valid === 1'b1);
    chk("bp_hs_noacc", bus.req_ready === 1'b0);
    tick();
    chk("bp_idle_rdy", bus.req_ready === 1'b1);
    chk("bp_idle_valid", bus.rsp_valid === 1'b0);
    tick();
    bus.req_valid = 1'b0;
    chk("bp2_valid", bus.rsp_valid === 1'b1);
    chk("bp2_out", bus.rsp_out === 4'd4);
    chk("bp2_cout", bus.rsp_cout === 1'b0);
    tick();

    bus.req_valid = 1'b1;
    bus.req_x     = 4'd6;
    bus.req_y     = 4'd3;
    bus.req_op    = 4'd3;
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", bus.rsp_valid === 1'b0);
    chk("mrst_rdy", bus.req_ready === 1'b1);
    chk("mrst_out", bus.rsp_out === 4'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mrst_stale", bus.rsp_valid === 1'b0);
    end

    do_op("rsvd", 4'd7, 4'd7, 4'd13, 4'd0, 1'b0, 1'b1, 1);
    do_op("pass", 4'd4, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
